dma_copy_ctrl: RTL and testbench
================================

# dma_copy_ctrl

Block-copy controller that sequences the single-port 256-byte data memory. It copies `len` bytes from `src` to `dst` inside the memory while sharing the one address/write port with the core's load/store path. The core always wins the port, and the copy engine stalls around it. It sits between the core LSU and the data memory; all memory traffic passes through it.

## Interface
Parameters:
- `AW`, 8, address width (memory depth 2**AW).
- `DW`, 8, data width.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle copy request; ignored unless idle.
- `src`  in  AW  source base address, sampled with `start`.
- `dst`  in  AW  destination base address, sampled with `start`.
- `len`  in  AW  byte count, sampled with `start`; 0 = no copy.
- `busy`  out  1  copy in progress (READ, WRITE or DONE).
- `done`  out  1  one-cycle completion pulse.
- `cpu_req`  in  1  core memory access this cycle (load or store).
- `cpu_wr_en`  in  1  core store enable, qualified by `cpu_req`.
- `cpu_addr`  in  AW  core address.
- `cpu_dat_in`  in  DW  core store data.
- `cpu_rd_data`  out  DW  core load data; equals `mem_data` (combinational).
- `mem_addr`  out  AW  memory address.
- `mem_wr_en`  out  1  memory write enable.
- `mem_dat_in`  out  DW  memory write data.
- `mem_data`  in  DW  memory combinational read data.

Clock is `clk`. Reset is synchronous and active-high on `reset`.

## Operation
- FSM states: IDLE, READ, WRITE, DONE. Registers: `src_ptr`, `dst_ptr`, `cnt` (AW bits each), `hold` (DW).
- **IDLE** with `start`=1:
  - Latch `src`/`dst`/`len` into `src_ptr`/`dst_ptr`/`cnt`.
  - Go to DONE if `len`==0, else go to READ.
  - `start` in any other state is ignored; no queueing.
- **Port mux** (combinational):
  - If `cpu_req`=1, the core owns the port: `mem_addr`=`cpu_addr`, `mem_wr_en`=`cpu_wr_en`, `mem_dat_in`=`cpu_dat_in`.
  - Otherwise the FSM drives the port.
  - With no core request and no engine access: `mem_wr_en`=0, `mem_addr`=0, `mem_dat_in`=0.
- **READ**:
  - If `cpu_req`=1, stay in READ; nothing is captured.
  - Otherwise drive `mem_addr`=`src_ptr`, capture `hold`<=`mem_data`, go to WRITE.
- **WRITE**:
  - If `cpu_req`=1, stay in WRITE; no write, `hold` is retained.
  - Otherwise drive `mem_addr`=`dst_ptr`, `mem_dat_in`=`hold`, `mem_wr_en`=1.
  - Then increment `src_ptr` and `dst_ptr` mod 2**AW (wrap 255->0) and decrement `cnt`.
  - Go to DONE if `cnt`==1, else go to READ.
- **DONE**: `done`=1 for exactly one cycle, then go to IDLE.
- **Overlap**: the copy is strictly forward and byte-serial. If `dst` lies in (`src`, `src`+`len`), already-copied bytes are re-read (pattern replication). This is defined behaviour, not an error.
- **Core stores into the copy window** mid-copy are visible to later engine reads; no hazard protection.
- **Reset**, including mid-copy:
  - Next state is IDLE; `busy`=0, `done`=0; `src_ptr`, `dst_ptr`, `cnt`, `hold` = 0.
  - No engine write occurs in the reset cycle. Core pass-through stays combinational.

## Timing
- Reset values: `busy`=0, `done`=0. `mem_wr_en` is 0 unless `cpu_req`&`cpu_wr_en`. `cpu_rd_data`=`mem_data` always.
- Core access has zero added latency. Mux, address and read data are combinational, and stores commit at the next `clk` edge.
- Uncontended copy, `start` sampled at edge E0:
  - Byte k (k = 0 .. `len`-1) is read in cycle 2k+1.
  - Byte k is written at edge E(2k+2).
  - `done` is high in the cycle after E(2·`len`).
  - `busy` is high from the cycle after E0 through the `done` cycle.
- Each cycle with `cpu_req`=1 during READ/WRITE adds exactly one cycle.
- `len`=0: `done` is high in the cycle after E0, with no memory access.
- `len`=0 is not the same as 256. Max copy is 255 bytes.

## Structure
- Shared package `dat_mem_pkg`:
  - `AW`/`DW` defaults.
  - `dma_state_t` enum {IDLE, READ, WRITE, DONE}.
- One natural sub-module, `mem_port_mux`: the combinational core/engine port selector.
- The FSM and pointer datapath stay in `dma_copy_ctrl`.
- The memory itself is instantiated outside, in the top level.

## Test plan
- **Basic copy**: preload mem[0x10..0x13]=A1,B2,C3,D4. Start with `src`=0x10, `dst`=0x80, `len`=4, `cpu_req`=0.
  -> mem[0x80..0x83]=A1,B2,C3,D4; `done` pulse 9 cycles after `start`; source bytes unchanged.
- **Core contention**: same copy, with `cpu_req`=1 (load of 0x05) in cycles 2 and 3.
  -> `done` 2 cycles later than baseline; `cpu_rd_data`=mem[0x05] in those cycles; destination still correct.
- **Wrap-around**: `src`=0xFE, `dst`=0x40, `len`=4, with mem[FE,FF,00,01]=1,2,3,4.
  -> mem[0x40..0x43]=1,2,3,4.
- **Overlap**: mem[0x20]=0x5A, `src`=0x20, `dst`=0x21, `len`=3.
  -> mem[0x21..0x23]=0x5A,0x5A,0x5A.
- **Edge controls**: `len`=0 -> `done` next cycle and no `mem_wr_en`. A second `start` while `busy` -> ignored and first copy unaffected.
- **Reset mid-copy**: assert `reset` in cycle 3 of a 4-byte copy.
  -> `busy`=0 next cycle; only byte 0 written; no further writes; a new `start` then works normally.

Source files
------------

// File: rtl/dat_mem_pkg.sv
// -----------------------------------------------------------------------------
// dat_mem_pkg
// Shared definitions for the data-memory block-copy controller:
//   AW_DEF / DW_DEF : default address / data widths (256 x 8 memory)
//   dma_state_t     : copy-engine state encoding
// -----------------------------------------------------------------------------
package dat_mem_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } dma_state_t;

endpackage

// File: rtl/dma_copy_ctrl_if.sv
// -----------------------------------------------------------------------------
// dma_copy_ctrl_if
// Bundles the copy-control handshake, the core load/store port and the
// data-memory port of dma_copy_ctrl.
//   start/src/dst/len : copy request and its parameters
//   busy/done         : copy status
//   cpu_*             : core LSU access (core always owns the port)
//   mem_*             : single shared memory port (mem_data is comb. read data)
// Modports:
//   slave  : the controller side
//   master : the environment side (core, control, memory)
// -----------------------------------------------------------------------------
interface dma_copy_ctrl_if
  import dat_mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();

  logic          start;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW-1:0] len;
  logic          busy;
  logic          done;

  logic          cpu_req;
  logic          cpu_wr_en;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_dat_in;
  logic [DW-1:0] cpu_rd_data;

  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [DW-1:0] mem_dat_in;
  logic [DW-1:0] mem_data;

  modport slave (
    input  start, src, dst, len,
    input  cpu_req, cpu_wr_en, cpu_addr, cpu_dat_in,
    input  mem_data,
    output busy, done, cpu_rd_data,
    output mem_addr, mem_wr_en, mem_dat_in
  );

  modport master (
    output start, src, dst, len,
    output cpu_req, cpu_wr_en, cpu_addr, cpu_dat_in,
    output mem_data,
    input  busy, done, cpu_rd_data,
    input  mem_addr, mem_wr_en, mem_dat_in
  );

endinterface

// File: rtl/mem_port_mux.sv
// -----------------------------------------------------------------------------
// mem_port_mux
// Combinational selector for the single data-memory port.
//   cpu_*  : core request, always has priority
//   eng_*  : copy-engine request, used only when the core is not accessing
//   mem_*  : resulting memory address / write enable / write data
// With neither side requesting, the port is driven to all zeros.
// -----------------------------------------------------------------------------
module mem_port_mux
  import dat_mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          cpu_req,
  input  logic          cpu_wr_en,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_dat_in,
  input  logic          eng_req,
  input  logic          eng_wr_en,
  input  logic [AW-1:0] eng_addr,
  input  logic [DW-1:0] eng_dat_in,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_dat_in
);

  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    mem_addr   = '0;
    mem_wr_en  = 1'b0;
    mem_dat_in = '0;
    if (cpu_req) begin
      mem_addr   = cpu_addr;
      mem_wr_en  = cpu_wr_en;
      mem_dat_in = cpu_dat_in;
    end else if (eng_req) begin
      mem_addr   = eng_addr;
      mem_wr_en  = eng_wr_en;
      mem_dat_in = eng_dat_in;
    end
  end

endmodule

// File: rtl/dma_copy_ctrl.sv
// -----------------------------------------------------------------------------
// dma_copy_ctrl
// Byte-serial block copy inside a single-port data memory, sharing the port
// with the core load/store path. The core always wins; the engine simply
// holds its state for any cycle in which cpu_req is high.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : dma_copy_ctrl_if.slave (copy control, core port, memory port)
// Each byte costs one READ cycle (capture into hold) and one WRITE cycle.
// Copies run strictly forward, so an overlapping dst replicates the pattern.
// -----------------------------------------------------------------------------
module dma_copy_ctrl
  import dat_mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  dma_copy_ctrl_if.slave  bus
);

  dma_state_t    state, state_nxt;
  logic [AW-1:0] src_ptr, dst_ptr, cnt;
  logic [DW-1:0] hold;

  logic          eng_req, eng_wr_en;
  logic [AW-1:0] eng_addr;
  logic [DW-1:0] eng_dat_in;
  logic          load_args, capture, advance;

  // Next-state and engine port request.
  always_comb begin
    state_nxt  = state;
    eng_req    = 1'b0;
    eng_wr_en  = 1'b0;
    eng_addr   = '0;
    eng_dat_in = '0;
    load_args  = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load_args = 1'b1;
          state_nxt = (bus.len == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (!bus.cpu_req) begin
          eng_req   = 1'b1;
          eng_addr  = src_ptr;
          capture   = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (!bus.cpu_req) begin
          eng_req    = 1'b1;
          eng_wr_en  = 1'b1;
          eng_addr   = dst_ptr;
          eng_dat_in = hold;
          advance    = 1'b1;
          state_nxt  = (cnt == AW'(1)) ? DONE : READ;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // The engine must not touch memory in a reset cycle, even mid-copy;
    // the core path is unaffected.
    if (reset) begin
      eng_req    = 1'b0;
      eng_wr_en  = 1'b0;
      eng_addr   = '0;
      eng_dat_in = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      src_ptr <= '0;
      dst_ptr <= '0;
      cnt     <= '0;
      hold    <= '0;
    end else begin
      state <= state_nxt;
      if (load_args) begin
        src_ptr <= bus.src;
        dst_ptr <= bus.dst;
        cnt     <= bus.len;
      end
      if (capture) begin
        hold <= bus.mem_data;
      end
      // Pointers wrap naturally at 2**AW.
      if (advance) begin
        src_ptr <= src_ptr + AW'(1);
        dst_ptr <= dst_ptr + AW'(1);
        cnt     <= cnt - AW'(1);
      end
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.cpu_rd_data = bus.mem_data;

  mem_port_mux #(
    .AW(AW),
    .DW(DW)
  ) u_mux (
    .cpu_req    (bus.cpu_req),
    .cpu_wr_en  (bus.cpu_wr_en),
    .cpu_addr   (bus.cpu_addr),
    .cpu_dat_in (bus.cpu_dat_in),
    .eng_req    (eng_req),
    .eng_wr_en  (eng_wr_en),
    .eng_addr   (eng_addr),
    .eng_dat_in (eng_dat_in),
    .mem_addr   (bus.mem_addr),
    .mem_wr_en  (bus.mem_wr_en),
    .mem_dat_in (bus.mem_dat_in)
  );

endmodule

// File: tb/tb_dma_copy_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dma_copy_ctrl
// Scoreboard bench for dma_copy_ctrl with a 256 x 8 memory model outside the
// DUT. Each copy is planned up front: the reference model walks the copy as a
// plain byte loop, spending one memory access per non-core cycle, and queues
// the expected engine writes, core load data and done cycle. A negedge
// monitor pops and compares whatever the DUT presents.
// -----------------------------------------------------------------------------
module tb_dma_copy_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dma_copy_ctrl_if #(.AW(8), .DW(8)) bus ();

  dma_copy_ctrl #(.AW(8), .DW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Memory instance outside the controller.
  logic [7:0] mem_arr [256];
  assign bus.mem_data = mem_arr[bus.mem_addr];
  always @(posedge clk) if (bus.mem_wr_en) mem_arr[bus.mem_addr] <= bus.mem_dat_in;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic       req;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } op_t;

  wr_t        exp_wr_q[$];
  int         exp_done_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] ref_mem [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got an event, expected none pending (cycle %0d)", name, cyc);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [7:0] e;
    wr_t        w;
    int         dc;
    if (cyc >= 2) begin
      if (bus.cpu_req) begin
        check("core_mux_wr_en", 32'(bus.mem_wr_en), 32'(bus.cpu_wr_en));
        check("core_mux_addr", 32'(bus.mem_addr), 32'(bus.cpu_addr));
        if (bus.cpu_wr_en) begin
          check("core_mux_wdata", 32'(bus.mem_dat_in), 32'(bus.cpu_dat_in));
        end else if (exp_rd_q.size() == 0) begin
          unexpected("core_load");
        end else begin
          e = exp_rd_q.pop_front();
          check("cpu_rd_data", 32'(bus.cpu_rd_data), 32'(e));
        end
      end else if (bus.mem_wr_en) begin
        if (exp_wr_q.size() == 0) begin
          unexpected("engine_write");
        end else begin
          w = exp_wr_q.pop_front();
          check("eng_wr_addr", 32'(bus.mem_addr), 32'(w.addr));
          check("eng_wr_data", 32'(bus.mem_dat_in), 32'(w.data));
        end
      end else if (!bus.busy) begin
        check("idle_port", 32'({bus.mem_addr, bus.mem_dat_in}), 32'd0);
      end
      if (bus.done) begin
        if (exp_done_q.size() == 0) begin
          unexpected("done_pulse");
        end else begin
          dc = exp_done_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(dc));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_store(input logic [7:0] a, input logic [7:0] d);
    bus.cpu_req    = 1'b1;
    bus.cpu_wr_en  = 1'b1;
    bus.cpu_addr   = a;
    bus.cpu_dat_in = d;
    ref_mem[a]     = d;
    tick();
    bus.cpu_req    = 1'b0;
    bus.cpu_wr_en  = 1'b0;
  endtask

  task automatic core_load(input logic [7:0] a);
    bus.cpu_req   = 1'b1;
    bus.cpu_wr_en = 1'b0;
    bus.cpu_addr  = a;
    exp_rd_q.push_back(ref_mem[a]);
    tick();
    bus.cpu_req   = 1'b0;
  endtask

  task automatic check_image();
    int bad = 0;
    for (int i = 0; i < 256; i++) if (mem_arr[i] !== ref_mem[i]) bad++;
    check("mem_image_bad_bytes", 32'(bad), 32'd0);
  endtask

  // One copy. Cycle j (1-based) is the j-th cycle after the start edge.
  // dir_mask[j] forces a core load of 0x05 in cycle j; otherwise a random
  // core access to 0xE0..0xFF occurs with probability stall_pct.
  task automatic do_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                         input int stall_pct, input logic [31:0] dir_mask,
                         input int reset_cyc, input bit extra_start);
    op_t        plan[$];
    op_t        op;
    int         acc      = 0;
    int         done_rel = -1;
    int         j        = 0;
    int         c0;
    logic [7:0] k8, sa, da;

    // Reference model: 2*len engine accesses, one per cycle without a core
    // access; odd accesses write byte k = acc/2 from src+k to dst+k.
    if (l == 8'd0) begin
      done_rel = 0;
    end else begin
      while (done_rel < 0) begin
        j++;
        op = '{req: 1'b0, wr: 1'b0, addr: 8'h00, data: 8'h00};
        if (j == reset_cyc || j > 4000) begin
          plan.push_back(op);
          break;
        end
        if (j < 32 && dir_mask[j]) begin
          op.req  = 1'b1;
          op.addr = 8'h05;
        end else if (int'($urandom_range(99)) < stall_pct) begin
          op.req  = 1'b1;
          op.wr   = 1'($urandom_range(1));
          op.addr = 8'hE0 + 8'($urandom_range(31));
          op.data = 8'($urandom);
        end
        if (op.req) begin
          if (op.wr) ref_mem[op.addr] = op.data;
          else       exp_rd_q.push_back(ref_mem[op.addr]);
        end else begin
          if (acc % 2 == 1) begin
            k8 = 8'(acc / 2);
            sa = s + k8;
            da = d + k8;
            ref_mem[da] = ref_mem[sa];
            exp_wr_q.push_back('{addr: da, data: ref_mem[sa]});
          end
          acc++;
          if (acc == 2 * int'(l)) done_rel = j;
        end
        plan.push_back(op);
      end
    end

    c0 = cyc + 1;
    if (done_rel >= 0) exp_done_q.push_back(c0 + done_rel);
    bus.src   = s;
    bus.dst   = d;
    bus.len   = l;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);

    for (int i = 0; i < plan.size(); i++) begin
      bus.cpu_req    = plan[i].req;
      bus.cpu_wr_en  = plan[i].wr;
      bus.cpu_addr   = plan[i].addr;
      bus.cpu_dat_in = plan[i].data;
      if (i + 1 == reset_cyc) reset = 1'b1;
      if (extra_start && i + 1 == 2) begin
        bus.start = 1'b1;
        bus.src   = 8'($urandom);
        bus.dst   = 8'($urandom);
        bus.len   = 8'($urandom_range(1, 255));
      end
      tick();
      bus.start     = 1'b0;
      bus.cpu_req   = 1'b0;
      bus.cpu_wr_en = 1'b0;
      if (reset) begin
        reset = 1'b0;
        check("busy_after_reset", 32'(bus.busy), 32'd0);
        check("done_after_reset", 32'(bus.done), 32'd0);
      end
    end
    repeat (3) tick();
    check("busy_when_idle", 32'(bus.busy), 32'd0);
    check_image();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] rs, rd, rl;
    bus.start      = 1'b0;
    bus.src        = '0;
    bus.dst        = '0;
    bus.len        = '0;
    bus.cpu_req    = 1'b0;
    bus.cpu_wr_en  = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_dat_in = '0;

    repeat (3) tick();
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
    reset = 1'b0;
    tick();

    // Fill the whole memory through the core port.
    for (int i = 0; i < 256; i++) core_store(8'(i), 8'($urandom));

    // Basic copy.
    core_store(8'h10, 8'hA1);
    core_store(8'h11, 8'hB2);
    core_store(8'h12, 8'hC3);
    core_store(8'h13, 8'hD4);
    do_copy(8'h10, 8'h80, 8'd4, 0, 32'h0, -1, 1'b0);
    check("basic_dst0", 32'(mem_arr[8'h80]), 32'hA1);
    check("basic_dst3", 32'(mem_arr[8'h83]), 32'hD4);

    // Core contention: loads of 0x05 in cycles 2 and 3.
    core_store(8'h80, 8'h00);
    do_copy(8'h10, 8'h80, 8'd4, 0, 32'h0000_000C, -1, 1'b0);

    // Wrap-around source.
    core_store(8'hFE, 8'h01);
    core_store(8'hFF, 8'h02);
    core_store(8'h00, 8'h03);
    core_store(8'h01, 8'h04);
    do_copy(8'hFE, 8'h40, 8'd4, 0, 32'h0, -1, 1'b0);
    check("wrap_dst3", 32'(mem_arr[8'h43]), 32'h04);

    // Overlapping forward copy replicates the first byte.
    core_store(8'h20, 8'h5A);
    do_copy(8'h20, 8'h21, 8'd3, 0, 32'h0, -1, 1'b0);
    check("overlap_dst2", 32'(mem_arr[8'h23]), 32'h5A);

    // len = 0, then a start while busy.
    do_copy(8'h30, 8'h90, 8'd0, 0, 32'h0, -1, 1'b0);
    do_copy(8'h31, 8'h70, 8'd5, 0, 32'h0, -1, 1'b1);

    // Reset during a READ cycle and during a WRITE cycle, then a normal copy.
    do_copy(8'h10, 8'h60, 8'd4, 0, 32'h0, 3, 1'b0);
    do_copy(8'h10, 8'h68, 8'd4, 0, 32'h0, 4, 1'b0);
    do_copy(8'h12, 8'h50, 8'd2, 0, 32'h0, -1, 1'b0);

    // Randomized copies with random core traffic in 0xE0..0xFF.
    for (int t = 0; t < 20; t++) begin
      rs = 8'($urandom_range(0, 8'hDF));
      rd = 8'($urandom_range(0, 8'h9F));
      rl = 8'($urandom_range(0, 32));
      do_copy(rs, rd, rl, 25, 32'h0, -1, (rl != 8'd0) && ($urandom_range(3) == 0));
    end

    for (int i = 0; i < 8; i++) core_load(8'($urandom_range(0, 255)));

    repeat (5) tick();
    check("pending_writes", 32'(exp_wr_q.size()), 32'd0);
    check("pending_done", 32'(exp_done_q.size()), 32'd0);
    check("pending_loads", 32'(exp_rd_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
